// File: rtl/vis_byte_framer.sv
// -----------------------------------------------------------------------------
// vis_byte_framer
//
// Receiving end of the correlator visibility stream on the bus-clock side.
// Each accepted visibility is a {real, imaginary} pair of ACCUM-bit values.
// The block packs these pairs into a framed byte stream for the host-link
// serialiser. A frame is laid out as follows:
//   HEADER byte, 8-bit sequence number, 2*ACCUM/8 payload bytes per entry
//   (MSB first), then an optional XOR checksum byte.
// A frame closes on the input 'last' flag or after TOTAL entries, whichever
// comes first. The frame length is checked against TOTAL.
//
// Optional feature macro: VIS_FRAMER_CHECKSUM_EN
//   defined   -> a trailing checksum byte (XOR of every frame byte) is sent,
//                and byte_last_o marks that checksum byte.
//   undefined -> no checksum; byte_last_o marks the final payload byte.
//
// Ports
//   bus_clock     in   sole clock
//   reset         in   synchronous, active-high
//   vis_valid_i   in   input visibility valid
//   vis_ready_o   out  input ready (high only while waiting for an entry)
//   vis_last_i    in   final visibility of the set
//   vis_revis_i   in   real part, ACCUM bits
//   vis_imvis_i   in   imaginary part, ACCUM bits
//   byte_valid_o  out  output byte valid
//   byte_ready_i  in   downstream ready
//   byte_data_o   out  output byte
//   byte_last_o   out  final byte of frame
//   frame_o       out  pulse after the final byte of a frame is accepted
//   err_short_o   out  pulse, 'last' arrived before TOTAL entries
//   err_long_o    out  pulse, TOTAL entries reached without 'last'
// -----------------------------------------------------------------------------
module vis_byte_framer #(
    parameter int          ACCUM  = 36,
    parameter int          TOTAL  = 540,
    parameter int          NBITS  = 10,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic               bus_clock,
    input  logic               reset,
    input  logic               vis_valid_i,
    output logic               vis_ready_o,
    input  logic               vis_last_i,
    input  logic [ACCUM-1:0]   vis_revis_i,
    input  logic [ACCUM-1:0]   vis_imvis_i,
    output logic               byte_valid_o,
    input  logic               byte_ready_i,
    output logic [7:0]         byte_data_o,
    output logic               byte_last_o,
    output logic               frame_o,
    output logic               err_short_o,
    output logic               err_long_o
);

    localparam int PW = 2 * ACCUM;
    localparam int NB = PW / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [IW-1:0]    IDX_LAST = IW'(NB - 1);
    localparam logic [NBITS-1:0] CNT_LAST = NBITS'(TOTAL - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        LOAD,
        SEND
`ifdef VIS_FRAMER_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       seq_q, seq_d;
    logic [NBITS-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    shift_q, shift_d;
    logic             lastFlag_q, lastFlag_d;
    logic [IW-1:0]    idx_q, idx_d;
`ifdef VIS_FRAMER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic             visReady_q, visReady_d;
    logic             byteValid_q, byteValid_d;
    logic [7:0]       byteData_q, byteData_d;
    logic             byteLast_q, byteLast_d;
    logic             frame_q, frame_d;
    logic             errShort_q, errShort_d;
    logic             errLong_q, errLong_d;

    logic             byteFire;
    logic             visFire;
    logic             frameEnd;
    logic             closing;

    // Handshakes are judged against the registered outputs, so ready never
    // depends combinationally on the upstream valid.
    assign byteFire = byteValid_q && byte_ready_i;
    assign visFire  = visReady_q && vis_valid_i;
    // byte_last_o is only ever set on the closing byte, so its acceptance
    // is the single point where a frame ends.
    assign frameEnd = byteFire && byteLast_q;
    assign closing  = lastFlag_q || (cnt_q == CNT_LAST);

    // State and all outputs are registered; synchronous reset abandons any
    // partial frame and restarts the sequence number at zero.
    always_ff @(posedge bus_clock) begin
        if (reset) begin
            state_q     <= IDLE;
            seq_q       <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            lastFlag_q  <= 1'b0;
            idx_q       <= '0;
`ifdef VIS_FRAMER_CHECKSUM_EN
            csum_q      <= '0;
`endif
            visReady_q  <= 1'b0;
            byteValid_q <= 1'b0;
            byteData_q  <= '0;
            byteLast_q  <= 1'b0;
            frame_q     <= 1'b0;
            errShort_q  <= 1'b0;
            errLong_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            lastFlag_q  <= lastFlag_d;
            idx_q       <= idx_d;
`ifdef VIS_FRAMER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
            visReady_q  <= visReady_d;
            byteValid_q <= byteValid_d;
            byteData_q  <= byteData_d;
            byteLast_q  <= byteLast_d;
            frame_q     <= frame_d;
            errShort_q  <= errShort_d;
            errLong_q   <= errLong_d;
        end
    end

    // Next-state logic. The output registers are loaded from the *next*
    // state so that they line up with state_q one cycle later; when a byte
    // is stalled nothing advances, which keeps data/last stable.
    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        lastFlag_d = lastFlag_q;
        idx_d      = idx_q;
`ifdef VIS_FRAMER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        errShort_d = 1'b0;
        errLong_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // The waiting entry is not consumed here; it is taken in LOAD.
                if (vis_valid_i) begin
                    state_d = HDR0;
                end
            end
            HDR0: begin
                if (byteFire) begin
                    state_d = HDR1;
                end
            end
            HDR1: begin
                if (byteFire) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (visFire) begin
                    shift_d    = {vis_revis_i, vis_imvis_i};
                    lastFlag_d = vis_last_i;
                    idx_d      = '0;
                    state_d    = SEND;
                    errShort_d = vis_last_i && (cnt_q != CNT_LAST);
                    errLong_d  = !vis_last_i && (cnt_q == CNT_LAST);
                end
            end
            SEND: begin
                if (byteFire) begin
                    if (idx_q == IDX_LAST) begin
                        if (closing) begin
`ifdef VIS_FRAMER_CHECKSUM_EN
                            state_d = CSUM;
`else
                            state_d = IDLE;
`endif
                        end else begin
                            cnt_d   = cnt_q + NBITS'(1);
                            state_d = LOAD;
                        end
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shift_d = shift_q << 8;
                    end
                end
            end
`ifdef VIS_FRAMER_CHECKSUM_EN
            CSUM: begin
                if (byteFire) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (frameEnd) begin
            seq_d = seq_q + 8'd1;
            cnt_d = '0;
        end

`ifdef VIS_FRAMER_CHECKSUM_EN
        // Running XOR of every byte handed over, headers included.
        if (frameEnd) begin
            csum_d = '0;
        end else if (byteFire) begin
            csum_d = csum_q ^ byteData_q;
        end
`endif

        visReady_d  = (state_d == LOAD);
        byteValid_d = 1'b0;
        byteData_d  = '0;
        case (state_d)
            HDR0: begin
                byteValid_d = 1'b1;
                byteData_d  = HEADER;
            end
            HDR1: begin
                byteValid_d = 1'b1;
                byteData_d  = seq_d;
            end
            SEND: begin
                byteValid_d = 1'b1;
                byteData_d  = shift_d[PW-1 -: 8];
            end
`ifdef VIS_FRAMER_CHECKSUM_EN
            CSUM: begin
                byteValid_d = 1'b1;
                byteData_d  = csum_d;
            end
`endif
            default: begin
                byteValid_d = 1'b0;
                byteData_d  = '0;
            end
        endcase

`ifdef VIS_FRAMER_CHECKSUM_EN
        byteLast_d = (state_d == CSUM);
`else
        byteLast_d = (state_d == SEND) && (idx_d == IDX_LAST) &&
                     (lastFlag_d || (cnt_d == CNT_LAST));
`endif

        frame_d = frameEnd;
    end

    assign vis_ready_o  = visReady_q;
    assign byte_valid_o = byteValid_q;
    assign byte_data_o  = byteData_q;
    assign byte_last_o  = byteLast_q;
    assign frame_o      = frame_q;
    assign err_short_o  = errShort_q;
    assign err_long_o   = errLong_q;

endmodule
